// File: rtl/mul_cpu_control_pkg.sv
// Shared encodings for the MulCPU control path: opcodes, FSM states, ALU functions and
// datapath mux selects, plus opcode classification helpers used by the FSM and decoder.
package mul_cpu_control_pkg;

   // Opcode field of the instruction register
   localparam logic [5:0] OpAdd   = 6'b000000;
   localparam logic [5:0] OpSub   = 6'b000001;
   localparam logic [5:0] OpAddi  = 6'b000010;
   localparam logic [5:0] OpOr    = 6'b010000;
   localparam logic [5:0] OpAnd   = 6'b010001;
   localparam logic [5:0] OpOri   = 6'b010010;
   localparam logic [5:0] OpSll   = 6'b011000;
   localparam logic [5:0] OpSlt   = 6'b100110;
   localparam logic [5:0] OpSltiu = 6'b100111;
   localparam logic [5:0] OpSw    = 6'b110000;
   localparam logic [5:0] OpLw    = 6'b110001;
   localparam logic [5:0] OpBeq   = 6'b110100;
   localparam logic [5:0] OpJ     = 6'b111000;
   localparam logic [5:0] OpJr    = 6'b111001;
   localparam logic [5:0] OpJal   = 6'b111010;
   localparam logic [5:0] OpHalt  = 6'b111111;

   typedef enum logic [2:0] {
      StIf    = 3'b000,
      StId    = 3'b001,
      StExeLs = 3'b010,
      StMem   = 3'b011,
      StWbLd  = 3'b100,
      StExeBr = 3'b101,
      StExeAl = 3'b110,
      StWbAl  = 3'b111
   } state_e;

   // ALU function select
   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluSlt = 3'b010;
   localparam logic [2:0] AluSrl = 3'b011;
   localparam logic [2:0] AluSll = 3'b100;
   localparam logic [2:0] AluOr  = 3'b101;
   localparam logic [2:0] AluAnd = 3'b110;
   localparam logic [2:0] AluXor = 3'b111;

   // Write register select
   localparam logic [1:0] RegDstRa = 2'b00;
   localparam logic [1:0] RegDstRt = 2'b01;
   localparam logic [1:0] RegDstRd = 2'b10;

   // Next PC select
   localparam logic [1:0] PcSrcSeq    = 2'b00;
   localparam logic [1:0] PcSrcBranch = 2'b01;
   localparam logic [1:0] PcSrcReg    = 2'b10;
   localparam logic [1:0] PcSrcJump   = 2'b11;

   function automatic logic is_rtype(input logic [5:0] op);
      return (op == OpAdd) || (op == OpSub) || (op == OpOr) || (op == OpAnd) ||
             (op == OpSll) || (op == OpSlt);
   endfunction

   function automatic logic is_itype_alu(input logic [5:0] op);
      return (op == OpAddi) || (op == OpOri) || (op == OpSltiu);
   endfunction

   function automatic logic is_alu_op(input logic [5:0] op);
      return is_rtype(op) || is_itype_alu(op);
   endfunction

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OpLw) || (op == OpSw);
   endfunction

   function automatic logic is_jump(input logic [5:0] op);
      return (op == OpJ) || (op == OpJr) || (op == OpJal);
   endfunction

   // Anything not recognised here retires in sID as a nop
   function automatic logic is_defined(input logic [5:0] op);
      return is_alu_op(op) || is_mem_op(op) || is_jump(op) || (op == OpBeq) ||
             (op == OpHalt);
   endfunction

endpackage

// File: rtl/mul_cpu_control_alu_decode.sv
// Opcode to ALU configuration: function select, B-operand source and immediate extension.
// Purely combinational; the FSM decides in which states these values are driven.
module mul_cpu_control_alu_decode
   import mul_cpu_control_pkg::*;
(
   input  logic [5:0] op,
   output logic [2:0] ALUOp,
   output logic       ALUSrcB,
   output logic       ExtSel
);

   always_comb begin
      ALUOp = AluAdd;
      case (op)
         OpAdd, OpAddi, OpLw, OpSw: ALUOp = AluAdd;
         OpSub, OpBeq:              ALUOp = AluSub;
         OpSlt, OpSltiu:            ALUOp = AluSlt;
         OpSll:                     ALUOp = AluSll;
         OpOr, OpOri:               ALUOp = AluOr;
         OpAnd:                     ALUOp = AluAnd;
         default:                   ALUOp = AluAdd;
      endcase
   end

   always_comb begin
      ALUSrcB = 1'b0;
      case (op)
         OpAddi, OpOri, OpSltiu, OpLw, OpSw: ALUSrcB = 1'b1;
         default:                            ALUSrcB = 1'b0;
      endcase
   end

   // Logical immediates and the unsigned compare take a zero-extended operand
   assign ExtSel = !((op == OpOri) || (op == OpSltiu));

endmodule

// File: rtl/mul_cpu_control.sv
// Multi-cycle MulCPU control unit: state register stepping IF/ID/EXE/MEM/WB and the
// combinational datapath enables derived from (state, op, zero).
module mul_cpu_control
   import mul_cpu_control_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] op,
   input  logic       zero,
   output logic [2:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtSel,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegData,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic [1:0] PCSrc
);

   state_e     state_q, state_d;
   logic [2:0] dec_aluop;
   logic       dec_srcb;
   logic       dec_ext;

   mul_cpu_control_alu_decode u_alu_decode (
      .op      (op),
      .ALUOp   (dec_aluop),
      .ALUSrcB (dec_srcb),
      .ExtSel  (dec_ext)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIf;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIf: state_d = StId;
         StId: begin
            if (is_alu_op(op)) begin
               state_d = StExeAl;
            end else if (is_mem_op(op)) begin
               state_d = StExeLs;
            end else if (op == OpBeq) begin
               state_d = StExeBr;
            end else if (op == OpHalt) begin
               state_d = StId;
            end else begin
               state_d = StIf;
            end
         end
         StExeAl: state_d = StWbAl;
         StWbAl:  state_d = StIf;
         StExeLs: state_d = StMem;
         StMem:   state_d = (op == OpLw) ? StWbLd : StIf;
         StWbLd:  state_d = StIf;
         StExeBr: state_d = StIf;
         default: state_d = StIf;
      endcase
   end

   assign state = state_q;

   // sIF drives only the fetch enables; op is still loading and must not leak through
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = AluAdd;
      ExtSel    = 1'b0;
      RegWre    = 1'b0;
      RegDst    = RegDstRa;
      WrRegData = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      PCSrc     = PcSrcSeq;

      if (state_q == StIf) begin
         IRWre    = 1'b1;
         InsMemRW = 1'b1;
      end else begin
         ALUSrcB   = dec_srcb;
         ALUOp     = dec_aluop;
         ExtSel    = dec_ext;
         WrRegData = (op != OpJal);
         if (is_rtype(op)) begin
            RegDst = RegDstRd;
         end else if (is_itype_alu(op) || (op == OpLw)) begin
            RegDst = RegDstRt;
         end else begin
            RegDst = RegDstRa;
         end

         unique case (state_q)
            StId: begin
               if (is_jump(op) || !is_defined(op)) begin
                  PCWre = 1'b1;
               end
               if ((op == OpJ) || (op == OpJal)) begin
                  PCSrc = PcSrcJump;
               end else if (op == OpJr) begin
                  PCSrc = PcSrcReg;
               end
               RegWre = (op == OpJal);
            end
            StExeBr: begin
               PCWre = 1'b1;
               PCSrc = zero ? PcSrcBranch : PcSrcSeq;
            end
            StMem: begin
               mRD   = (op == OpLw);
               mWR   = (op == OpSw);
               PCWre = (op == OpSw);
            end
            StWbLd: begin
               DBDataSrc = 1'b1;
               RegWre    = 1'b1;
               PCWre     = 1'b1;
            end
            StWbAl: begin
               RegWre = 1'b1;
               PCWre  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_cpu_control.sv
// Self-checking bench for mul_cpu_control: per-cycle expected output vectors are queued
// for each instruction and compared against the DUT one cycle at a time.
module tb_mul_cpu_control;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] op = 6'b000000;
   logic       zero = 1'b0;
   logic [2:0] state;
   logic       PCWre, IRWre, InsMemRW, ALUSrcB, ExtSel, RegWre, WrRegData, DBDataSrc;
   logic       mRD, mWR;
   logic [2:0] ALUOp;
   logic [1:0] RegDst, PCSrc;

   int checks = 0;
   int errors = 0;
   logic [19:0] sb[$];
   logic [19:0] got, exp_v;

   mul_cpu_control dut (
      .CLK       (CLK),
      .RST       (RST),
      .op        (op),
      .zero      (zero),
      .state     (state),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .InsMemRW  (InsMemRW),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ExtSel    (ExtSel),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .WrRegData (WrRegData),
      .DBDataSrc (DBDataSrc),
      .mRD       (mRD),
      .mWR       (mWR),
      .PCSrc     (PCSrc)
   );

   always #5 CLK = ~CLK;

   assign got = {state, PCWre, IRWre, InsMemRW, ALUSrcB, ALUOp, ExtSel, RegWre, RegDst,
                 WrRegData, DBDataSrc, mRD, mWR, PCSrc};

   // Field order: state pcwre irwre imrw srcb aluop ext regwre regdst wrd dbs mrd mwr pcsrc
   function automatic logic [19:0] v(input logic [2:0] st, input logic pcw, input logic irw,
                                     input logic imr, input logic srcb, input logic [2:0] aop,
                                     input logic ext, input logic rw, input logic [1:0] rd,
                                     input logic wrd, input logic dbs, input logic mrd,
                                     input logic mwr, input logic [1:0] pcs);
      return {st, pcw, irw, imr, srcb, aop, ext, rw, rd, wrd, dbs, mrd, mwr, pcs};
   endfunction

   localparam logic [19:0] VIf = {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0,
                                  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

   // ALU-class instruction: IF, ID, EXE_AL, WB_AL, IF
   task automatic push_alu(input logic srcb, input logic [2:0] aop, input logic ext,
                           input logic [1:0] rd);
      sb.push_back(VIf);
      sb.push_back(v(3'b001, 0, 0, 0, srcb, aop, ext, 0, rd, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b110, 0, 0, 0, srcb, aop, ext, 0, rd, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b111, 1, 0, 0, srcb, aop, ext, 1, rd, 1, 0, 0, 0, 2'b00));
      sb.push_back(VIf);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #2;
      checks++;
      if (got !== VIf) begin
         errors++;
         $display("FAIL reset_async got %h expected %h", got, VIf);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (got !== VIf) begin
         errors++;
         $display("FAIL reset_held got %h expected %h", got, VIf);
      end
      RST = 1'b0;
   endtask

   task automatic test_add();
      op = 6'b000000;
      push_alu(1'b0, 3'b000, 1'b1, 2'b10);
      for (int c = 0; sb.size() != 0; c++) begin
         exp_v = sb.pop_front();
         #1;
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL add cycle %0d got %h expected %h", c, got, exp_v);
         end
         if (sb.size() != 0) begin
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic test_alu_mix();
      logic [5:0] ops[5] = '{6'b000001, 6'b010010, 6'b100111, 6'b011000, 6'b010001};
      string      nm[5]  = '{"sub", "ori", "sltiu", "sll", "and"};
      // Back-to-back: the trailing IF of one instruction is the leading IF of the next
      for (int i = 0; i < 5; i++) begin
         op = ops[i];
         case (i)
            0: push_alu(1'b0, 3'b001, 1'b1, 2'b10);
            1: push_alu(1'b1, 3'b101, 1'b0, 2'b01);
            2: push_alu(1'b1, 3'b010, 1'b0, 2'b01);
            3: push_alu(1'b0, 3'b100, 1'b1, 2'b10);
            default: push_alu(1'b0, 3'b110, 1'b1, 2'b10);
         endcase
         for (int c = 0; sb.size() != 0; c++) begin
            exp_v = sb.pop_front();
            #1;
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL %s cycle %0d got %h expected %h", nm[i], c, got, exp_v);
            end
            if (sb.size() != 0) begin
               @(posedge CLK);
               #1;
            end
         end
      end
   endtask

   task automatic test_lw_sw();
      op = 6'b110001;
      sb.push_back(VIf);
      sb.push_back(v(3'b001, 0, 0, 0, 1, 3'b000, 1, 0, 2'b01, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b010, 0, 0, 0, 1, 3'b000, 1, 0, 2'b01, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b011, 0, 0, 0, 1, 3'b000, 1, 0, 2'b01, 1, 0, 1, 0, 2'b00));
      sb.push_back(v(3'b100, 1, 0, 0, 1, 3'b000, 1, 1, 2'b01, 1, 1, 0, 0, 2'b00));
      sb.push_back(VIf);
      for (int c = 0; sb.size() != 0; c++) begin
         exp_v = sb.pop_front();
         #1;
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL lw cycle %0d got %h expected %h", c, got, exp_v);
         end
         if (sb.size() != 0) begin
            @(posedge CLK);
            #1;
         end
      end
      op = 6'b110000;
      sb.push_back(VIf);
      sb.push_back(v(3'b001, 0, 0, 0, 1, 3'b000, 1, 0, 2'b00, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b010, 0, 0, 0, 1, 3'b000, 1, 0, 2'b00, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b011, 1, 0, 0, 1, 3'b000, 1, 0, 2'b00, 1, 0, 0, 1, 2'b00));
      sb.push_back(VIf);
      for (int c = 0; sb.size() != 0; c++) begin
         exp_v = sb.pop_front();
         #1;
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL sw cycle %0d got %h expected %h", c, got, exp_v);
         end
         if (sb.size() != 0) begin
            @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         op   = 6'b110100;
         zero = z[0];
         sb.push_back(VIf);
         sb.push_back(v(3'b001, 0, 0, 0, 0, 3'b001, 1, 0, 2'b00, 1, 0, 0, 0, 2'b00));
         sb.push_back(v(3'b101, 1, 0, 0, 0, 3'b001, 1, 0, 2'b00, 1, 0, 0, 0,
                        z[0] ? 2'b01 : 2'b00));
         sb.push_back(VIf);
         for (int c = 0; sb.size() != 0; c++) begin
            exp_v = sb.pop_front();
            #1;
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL beq_zero%0d cycle %0d got %h expected %h", z, c, got, exp_v);
            end
            if (sb.size() != 0) begin
               @(posedge CLK);
               #1;
            end
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jumps();
      logic [5:0] ops[4] = '{6'b111010, 6'b111000, 6'b111001, 6'b000011};
      string      nm[4]  = '{"jal", "j", "jr", "undef"};
      for (int i = 0; i < 4; i++) begin
         op = ops[i];
         sb.push_back(VIf);
         case (i)
            0: sb.push_back(v(3'b001, 1, 0, 0, 0, 3'b000, 1, 1, 2'b00, 0, 0, 0, 0, 2'b11));
            1: sb.push_back(v(3'b001, 1, 0, 0, 0, 3'b000, 1, 0, 2'b00, 1, 0, 0, 0, 2'b11));
            2: sb.push_back(v(3'b001, 1, 0, 0, 0, 3'b000, 1, 0, 2'b00, 1, 0, 0, 0, 2'b10));
            default:
               sb.push_back(v(3'b001, 1, 0, 0, 0, 3'b000, 1, 0, 2'b00, 1, 0, 0, 0, 2'b00));
         endcase
         sb.push_back(VIf);
         for (int c = 0; sb.size() != 0; c++) begin
            exp_v = sb.pop_front();
            #1;
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL %s cycle %0d got %h expected %h", nm[i], c, got, exp_v);
            end
            if (sb.size() != 0) begin
               @(posedge CLK);
               #1;
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      op = 6'b000000;
      sb.push_back(VIf);
      sb.push_back(v(3'b001, 0, 0, 0, 0, 3'b000, 1, 0, 2'b10, 1, 0, 0, 0, 2'b00));
      sb.push_back(v(3'b110, 0, 0, 0, 0, 3'b000, 1, 0, 2'b10, 1, 0, 0, 0, 2'b00));
      for (int c = 0; sb.size() != 0; c++) begin
         exp_v = sb.pop_front();
         #1;
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_pre cycle %0d got %h expected %h", c, got, exp_v);
         end
         if (sb.size() != 0) begin
            @(posedge CLK);
            #1;
         end
      end
      RST = 1'b1;
      #1;
      checks++;
      if (got !== VIf) begin
         errors++;
         $display("FAIL rst_mid_async got %h expected %h", got, VIf);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
      checks++;
      if (got !== VIf) begin
         errors++;
         $display("FAIL rst_mid_release got %h expected %h", got, VIf);
      end
   endtask

   task automatic test_halt();
      op = 6'b111111;
      sb.push_back(VIf);
      for (int i = 0; i < 20; i++) begin
         sb.push_back(v(3'b001, 0, 0, 0, 0, 3'b000, 1, 0, 2'b00, 1, 0, 0, 0, 2'b00));
      end
      for (int c = 0; sb.size() != 0; c++) begin
         exp_v = sb.pop_front();
         #1;
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL halt cycle %0d got %h expected %h", c, got, exp_v);
         end
         @(posedge CLK);
         #1;
      end
      RST = 1'b1;
      #1;
      checks++;
      if (got !== VIf) begin
         errors++;
         $display("FAIL halt_reset got %h expected %h", got, VIf);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_mix();
      test_lw_sw();
      test_beq();
      test_jumps();
      test_reset_mid();
      test_halt();
      test_add();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
